// File: rtl/rv_lsu.sv
// rv_lsu: RISC-V load/store unit. It takes one core request at a time,
// faults misaligned or illegal accesses locally, and otherwise runs one
// lane-aligned bus transaction. Load data is shifted down, truncated and
// sign- or zero-extended before it is returned.
module rv_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic                store_q, store_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic                fault_q, fault_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   logic                req_fault;
   logic [OFF_W-1:0]    off;
   logic [OFF_W+2:0]    shamt;
   logic [NB-1:0]       size_mask;
   logic [XLEN-1:0]     rshift;
   logic [XLEN-1:0]     load_data;

   // Byte offset inside the bus word and the matching bit shift.
   assign off   = addr_q[OFF_W-1:0];
   assign shamt = {off, 3'b000};

   // Classify the incoming request: misalignment, unsupported size, bad store size.
   always_comb begin
      req_fault = 1'b0;
      case (req_funct3)
         3'b001, 3'b101: req_fault = req_addr[0];
         3'b010:         req_fault = |req_addr[1:0];
         3'b110:         req_fault = (XLEN == 32) || (|req_addr[1:0]);
         3'b011:         req_fault = (XLEN == 32) || (|req_addr[2:0]);
         3'b111:         req_fault = 1'b1;
         default:        req_fault = 1'b0;
      endcase
      if (req_store && req_funct3[2]) begin
         req_fault = 1'b1;
      end
   end

   // Access-size byte mask before it is moved to the addressed lane.
   always_comb begin
      size_mask = '0;
      case (funct3_q[1:0])
         2'b00:   size_mask = NB'(1);
         2'b01:   size_mask = NB'(3);
         2'b10:   size_mask = NB'(15);
         default: size_mask = '1;
      endcase
   end

   // Bring the addressed bytes down to bit 0 and extend them to XLEN.
   always_comb begin
      rshift    = mem_rdata >> shamt;
      load_data = rshift;
      case (funct3_q)
         3'b000:  load_data = XLEN'($signed(rshift[7:0]));
         3'b100:  load_data = XLEN'(rshift[7:0]);
         3'b001:  load_data = XLEN'($signed(rshift[15:0]));
         3'b101:  load_data = XLEN'(rshift[15:0]);
         3'b010:  load_data = XLEN'($signed(rshift[31:0]));
         3'b110:  load_data = XLEN'(rshift[31:0]);
         default: load_data = rshift;
      endcase
   end

   // Next-state logic: accept in IDLE, hand-shake in ISSUE, collect data in WAIT.
   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fault_d  = fault_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               fault_d  = req_fault;
               rdata_d  = '0;
               state_d  = req_fault ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               state_d = store_q ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               rdata_d = load_data;
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers; reset abandons any request in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fault_q  <= fault_d;
         rdata_q  <= rdata_d;
      end
   end

   // Outputs decode straight from the state so they are clean zeros elsewhere.
   always_comb begin
      req_ready = (state_q == IDLE) && !reset;
      rsp_valid = 1'b0;
      rsp_fault = 1'b0;
      rsp_rdata = '0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      if (state_q == RESP) begin
         rsp_valid = 1'b1;
         rsp_fault = fault_q;
         rsp_rdata = rdata_q;
      end
      if (state_q == ISSUE) begin
         mem_valid = 1'b1;
         mem_we    = store_q;
         mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         mem_be    = size_mask << off;
         mem_wdata = wdata_q << shamt;
      end
   end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed scoreboard bench for rv_lsu. A 32-bit and a 64-bit
// instance share the request and bus stimulus; a per-instance valid selects
// which one is addressed. Expected responses and bus beats are queued at
// accept time and popped by a negedge monitor.
module tb_rv_lsu;

   typedef struct {
      logic [63:0] rdata;
      logic        fault;
      int          acc;
      int          lat;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  be;
      logic [63:0] wd;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        r_valid, r_store;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;
   logic [63:0] r_wdata;
   int          r_sel;
   logic        mem_ready, mem_rvalid;
   logic [63:0] mem_rdata;
   logic        req_valid0, req_valid1;

   logic        rdy0, rsp_v0, rsp_f0, mv0, we0;
   logic [31:0] rsp_d0, ma0, mwd0;
   logic [3:0]  be0;
   logic        rdy1, rsp_v1, rsp_f1, mv1, we1;
   logic [63:0] rsp_d1, mwd1;
   logic [31:0] ma1;
   logic [7:0]  be1;

   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   int   last_rsp = -1;
   int   last_id = -1;
   rsp_t rq0[$], rq1[$];
   bus_t bq0[$], bq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req_valid0 = r_valid && (r_sel == 0);
   assign req_valid1 = r_valid && (r_sel == 1);

   rv_lsu #(.XLEN(32), .ADDR_W(32)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(rdy0), .req_store(r_store),
      .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata[31:0]),
      .rsp_valid(rsp_v0), .rsp_rdata(rsp_d0), .rsp_fault(rsp_f0),
      .mem_valid(mv0), .mem_ready(mem_ready), .mem_we(we0), .mem_addr(ma0),
      .mem_be(be0), .mem_wdata(mwd0), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata[31:0])
   );

   rv_lsu #(.XLEN(64), .ADDR_W(32)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(rdy1), .req_store(r_store),
      .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata),
      .rsp_valid(rsp_v1), .rsp_rdata(rsp_d1), .rsp_fault(rsp_f1),
      .mem_valid(mv1), .mem_ready(mem_ready), .mem_we(we1), .mem_addr(ma1),
      .mem_be(be1), .mem_wdata(mwd1), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic mon_rsp(input int id, input logic v, input logic [63:0] d, input logic f);
      rsp_t e;
      bit   empty;
      if (!v) begin
         chk($sformatf("rsp%0d_idle_zero", id), d | 64'(f), 64'h0);
         return;
      end
      empty = (id == 0) ? (rq0.size() == 0) : (rq1.size() == 0);
      if (empty) begin
         chk($sformatf("rsp%0d_unexpected", id), 64'(v), 64'h0);
         return;
      end
      if (id == 0) e = rq0.pop_front();
      else         e = rq1.pop_front();
      chk($sformatf("rsp%0d_rdata", id), d, e.rdata);
      chk($sformatf("rsp%0d_fault", id), 64'(f), 64'(e.fault));
      chk($sformatf("rsp%0d_latency", id), 64'(cyc - e.acc + 1), 64'(e.lat));
      $display("rsp%0d: rdata=0x%0h fault=%0b latency=%0d", id, d, f, cyc - e.acc + 1);
   endtask

   task automatic mon_bus(input int id, input logic mv, input logic we, input logic [31:0] a,
                          input logic [7:0] be, input logic [63:0] wd, input logic rdy);
      bus_t e;
      bit   empty;
      if (!mv) begin
         chk($sformatf("bus%0d_idle_zero", id), 64'(we) | 64'(a) | 64'(be) | wd, 64'h0);
         return;
      end
      empty = (id == 0) ? (bq0.size() == 0) : (bq1.size() == 0);
      if (empty) begin
         chk($sformatf("bus%0d_unexpected", id), 64'(mv), 64'h0);
         return;
      end
      if (id == 0) e = bq0[0];
      else         e = bq1[0];
      chk($sformatf("bus%0d_we", id), 64'(we), 64'(e.we));
      chk($sformatf("bus%0d_addr", id), 64'(a), 64'(e.addr));
      chk($sformatf("bus%0d_be", id), 64'(be), 64'(e.be));
      chk($sformatf("bus%0d_wdata", id), wd, e.wd);
      if (rdy) begin
         if (id == 0) e = bq0.pop_front();
         else         e = bq1.pop_front();
      end
   endtask

   // Monitor: compares both instances on every falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         mon_rsp(0, rsp_v0, 64'(rsp_d0), rsp_f0);
         mon_bus(0, mv0, we0, ma0, {4'h0, be0}, 64'(mwd0), mem_ready);
         mon_rsp(1, rsp_v1, rsp_d1, rsp_f1);
         mon_bus(1, mv1, we1, ma1, be1, mwd1, mem_ready);
      end
   end

   // Called between edges; returns at the edge on which the request was taken.
   task automatic wait_accept(input int id, output bit ok);
      bit rdy;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rdy = (id == 0) ? rdy0 : rdy1;
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 64'(ok), 64'h1);
   endtask

   task automatic xact(input int id, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd, input int dly,
                       input bit hold, input bit noise, input bit flt,
                       input logic [7:0] ebe, input logic [63:0] ewd, input logic [63:0] erd);
      bit   ok;
      rsp_t r;
      bus_t b;
      int   acc;
      r_sel = id; r_store = st; r_f3 = f3; r_addr = addr; r_wdata = wd; r_valid = 1'b1;
      wait_accept(id, ok);
      if (!ok) begin
         r_valid = 1'b0;
         return;
      end
      #1;
      acc = cyc;
      if (!hold) r_valid = 1'b0;
      if (last_rsp >= 0 && last_id == id) chk("b2b_accept_cycle", 64'(acc), 64'(last_rsp + 2));
      r.rdata = erd; r.fault = flt; r.acc = acc;
      r.lat   = flt ? 1 : (st ? dly + 2 : dly + 3);
      if (id == 0) rq0.push_back(r); else rq1.push_back(r);
      if (!flt) begin
         b.we = st; b.be = ebe; b.wd = ewd;
         b.addr = addr & ((id == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8);
         if (id == 0) bq0.push_back(b); else bq1.push_back(b);
         for (int i = 0; i < dly; i++) begin
            if (noise) begin
               mem_rvalid = 1'b1;
               mem_rdata  = ~rd;
            end
            @(posedge clk); #1;
         end
         mem_rvalid = 1'b0;
         mem_ready  = 1'b1;
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (!st) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((id == 0) ? rsp_v0 : rsp_v1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("rsp_timeout", 64'(ok), 64'h1);
      last_rsp = cyc;
      last_id  = id;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      bus_t b;
      reset = 1'b0; r_valid = 1'b0; r_store = 1'b0; r_f3 = 3'b000; r_addr = '0;
      r_wdata = '0; r_sel = 0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready0", 64'(rdy0), 64'h0);
      chk("reset_req_ready1", 64'(rdy1), 64'h0);
      chk("reset_outputs0", 64'(rsp_v0) | 64'(mv0) | 64'(rsp_d0), 64'h0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_ready0", 64'(rdy0), 64'h1);
      chk("post_reset_ready1", 64'(rdy1), 64'h1);

      //   id st f3      addr      wdata              rdata              dly hold noise flt be     exp wdata            exp rdata
      xact(0, 0, 3'b000, 32'h103, 64'h0,             64'h80FFFFFF,         0, 0, 0, 0, 8'h08, 64'h0,                64'hFFFFFF80);
      xact(0, 1, 3'b001, 32'h202, 64'h0000ABCD,      64'h0,                3, 0, 0, 0, 8'h0C, 64'hABCD0000,         64'h0);
      xact(0, 0, 3'b010, 32'h201, 64'h0,             64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 0, 3'b001, 32'h102, 64'h0,             64'h7FFF1234,         2, 0, 1, 0, 8'h0C, 64'h0,                64'h00007FFF);
      xact(0, 0, 3'b101, 32'h100, 64'h0,             64'h12348001,         0, 0, 0, 0, 8'h03, 64'h0,                64'h00008001);
      xact(0, 0, 3'b100, 32'h101, 64'h0,             64'h00009A00,         1, 0, 0, 0, 8'h02, 64'h0,                64'h0000009A);
      xact(0, 1, 3'b000, 32'h103, 64'h12345678,      64'h0,                0, 0, 0, 0, 8'h08, 64'h78000000,         64'h0);
      xact(0, 1, 3'b010, 32'h204, 64'hDEADBEEF,      64'h0,                0, 0, 0, 0, 8'h0F, 64'hDEADBEEF,         64'h0);
      xact(0, 0, 3'b011, 32'h000, 64'h0,             64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 0, 3'b110, 32'h000, 64'h0,             64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 1, 3'b100, 32'h000, 64'h0,             64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 0, 3'b111, 32'h000, 64'h0,             64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 1, 3'b001, 32'h201, 64'h1234,          64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 1, 3'b010, 32'h202, 64'h1234,          64'h0,                0, 0, 0, 1, 8'h00, 64'h0,                64'h0);
      xact(0, 0, 3'b010, 32'h208, 64'h0,             64'h80000001,         0, 1, 0, 0, 8'h0F, 64'h0,                64'h80000001);
      xact(0, 0, 3'b010, 32'h208, 64'h0,             64'h80000001,         0, 0, 0, 0, 8'h0F, 64'h0,                64'h80000001);

      // Reset while the bus request is outstanding in ISSUE.
      r_sel = 0; r_store = 1'b0; r_f3 = 3'b010; r_addr = 32'h300; r_wdata = '0; r_valid = 1'b1;
      wait_accept(0, ok);
      #1 r_valid = 1'b0;
      b.we = 1'b0; b.addr = 32'h300; b.be = 8'h0F; b.wd = '0;
      bq0.push_back(b);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_issue_mem_valid", 64'(mv0), 64'h0);
      chk("rst_issue_req_ready", 64'(rdy0), 64'h0);
      bq0.delete();
      @(posedge clk); #1 reset = 1'b0;
      #1 chk("rst_issue_release_ready", 64'(rdy0), 64'h1);
      @(negedge clk);

      // Reset while waiting for read data; late read data must be ignored.
      r_addr = 32'h304; r_valid = 1'b1;
      wait_accept(0, ok);
      #1 r_valid = 1'b0;
      b.addr = 32'h304;
      bq0.push_back(b);
      mem_ready = 1'b1;
      @(posedge clk); #1 mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_wait_mem_valid", 64'(mv0), 64'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hFFFF_FFFF;
      @(negedge clk);
      chk("rst_wait_no_rsp", 64'(rsp_v0), 64'h0);
      chk("rst_wait_req_ready", 64'(rdy0), 64'h0);
      @(posedge clk); #1 reset = 1'b0;
      #1 chk("rst_wait_release_ready", 64'(rdy0), 64'h1);
      @(posedge clk); #1 mem_rvalid = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      chk("rst_wait_idle_no_rsp", 64'(rsp_v0), 64'h0);
      chk("rst_wait_idle_ready", 64'(rdy0), 64'h1);
      last_rsp = -1;

      //   id st f3      addr      wdata                  rdata                  dly hold noise flt be     exp wdata               exp rdata
      xact(1, 0, 3'b110, 32'h104, 64'h0,                 64'h89ABCDEF_00000000, 0, 0, 0, 0, 8'hF0, 64'h0,                   64'h00000000_89ABCDEF);
      xact(1, 0, 3'b010, 32'h104, 64'h0,                 64'h89ABCDEF_00000000, 0, 0, 0, 0, 8'hF0, 64'h0,                   64'hFFFFFFFF_89ABCDEF);
      xact(1, 0, 3'b011, 32'h108, 64'h0,                 64'h01234567_89ABCDEF, 1, 0, 0, 0, 8'hFF, 64'h0,                   64'h01234567_89ABCDEF);
      xact(1, 1, 3'b011, 32'h110, 64'hCAFEF00D_12345678, 64'h0,                 0, 0, 0, 0, 8'hFF, 64'hCAFEF00D_12345678,   64'h0);
      xact(1, 1, 3'b001, 32'h106, 64'h0000BEEF,          64'h0,                 2, 0, 0, 0, 8'hC0, 64'hBEEF0000_00000000,   64'h0);
      xact(1, 0, 3'b011, 32'h104, 64'h0,                 64'h0,                 0, 0, 0, 1, 8'h00, 64'h0,                   64'h0);
      xact(1, 0, 3'b000, 32'h105, 64'h0,                 64'h00007F00_00000000, 0, 0, 0, 0, 8'h20, 64'h0,                   64'h00000000_0000007F);
      xact(1, 0, 3'b101, 32'h10E, 64'h0,                 64'hFFEE0000_00000000, 0, 0, 0, 0, 8'hC0, 64'h0,                   64'h00000000_0000FFEE);
      xact(1, 0, 3'b001, 32'h10E, 64'h0,                 64'hFFEE0000_00000000, 1, 0, 1, 0, 8'hC0, 64'h0,                   64'hFFFFFFFF_FFFFFFEE);
      xact(1, 1, 3'b010, 32'h104, 64'h11223344,          64'h0,                 0, 0, 0, 0, 8'hF0, 64'h11223344_00000000,   64'h0);
      xact(1, 1, 3'b110, 32'h100, 64'h11223344,          64'h0,                 0, 0, 0, 1, 8'h00, 64'h0,                   64'h0);

      repeat (5) @(negedge clk);
      chk("rsp_queue0_drained", 64'(rq0.size()), 64'h0);
      chk("rsp_queue1_drained", 64'(rq1.size()), 64'h0);
      chk("bus_queue0_drained", 64'(bq0.size()), 64'h0);
      chk("bus_queue1_drained", 64'(bq1.size()), 64'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 SHALL have parameter: XLEN, 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter: ADDR_W, 32, byte-address width.
REQ-003 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: req_valid  in  1  core request present.
REQ-006 SHALL have port: req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port: req_store  in  1  1 = store, 0 = load.
REQ-008 SHALL have port: req_funct3  in  3  RV access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-009 SHALL have port: req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port: req_wdata  in  XLEN  store data, right-justified.
REQ-011 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
REQ-013 SHALL have port: rsp_fault  out  1  misaligned or illegal access; qualified by rsp_valid.
REQ-014 SHALL have port: mem_valid  out  1  bus request.
REQ-015 SHALL have port: mem_ready  in  1  bus accepts request.
REQ-016 SHALL have port: mem_we  out  1  bus write.
REQ-017 SHALL have port: mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits forced to 0.
REQ-018 SHALL have port: mem_be  out  XLEN/8  byte-lane enables.
REQ-019 SHALL have port: mem_wdata  out  XLEN  lane-aligned store data.
REQ-020 SHALL have port: mem_rvalid  in  1  read data valid.
REQ-021 SHALL have port: mem_rdata  in  XLEN  full-width read data.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-023 SHALL drive req_ready=1 only in IDLE; request accepted when req_valid & req_ready, with all req_* fields latched that edge.
REQ-024 SHALL fault if: H/HU and addr[0]!=0; W/WU and addr[1:0]!=0; D and addr[2:0]!=0; funct3 111; or D/WU when XLEN=32; store with funct3 1xx is also a fault.
REQ-025 Faulting access SHALL go IDLE->RESP without any bus request (mem_valid stays 0).
REQ-026 Legal access SHALL go IDLE->ISSUE; in ISSUE mem_valid=1 and mem_we/addr/be/wdata held stable until mem_ready=1.
REQ-027 On ISSUE & mem_ready: store -> RESP; load -> WAIT.
REQ-028 In WAIT, on mem_rvalid=1 SHALL capture mem_rdata and go to RESP; mem_rvalid in ISSUE or IDLE SHALL be ignored.
REQ-029 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; no backpressure on rsp.
REQ-030 Lane offset off = addr[log2(XLEN/8)-1:0]; mem_be = size mask (1/3/F/FF) << off; mem_wdata = req_wdata shifted left by 8*off.
REQ-031 Load data SHALL be mem_rdata >> 8*off, truncated to size, sign-extended for B/H/W, zero-extended for BU/HU/WU; D passed through.
REQ-032 Minimum latency from accept edge T: fault rsp at T+1; store rsp at T+2; load rsp at T+3 (mem_ready at T+1, mem_rvalid at T+2).
REQ-033 Outputs mem_* SHALL be 0 outside ISSUE; rsp_rdata/rsp_fault SHALL be 0 outside RESP.

Reset
REQ-034 Reset SHALL force IDLE, all outputs 0, req_ready 0 while reset asserted, and discard latched request.
REQ-035 Reset mid-ISSUE/WAIT SHALL drop mem_valid asynchronously and SHALL produce no rsp_valid for the abandoned request.

Verification
REQ-036 XLEN=32 LB addr 0x103, mem_rdata 0x80FFFFFF -> mem_be 4'b1000, mem_addr 0x100, rsp_rdata 0xFFFFFF80 at T+3.
REQ-037 XLEN=32 SH addr 0x202, wdata 0x0000ABCD, mem_ready delayed 3 cycles -> mem_be 4'b1100, mem_wdata 0xABCD0000 stable all 4 ISSUE cycles, rsp_valid one cycle after handshake.
REQ-038 XLEN=32 LW addr 0x201 -> rsp_valid at T+1, rsp_fault 1, rsp_rdata 0, mem_valid never 1.
REQ-039 XLEN=64 LWU addr 0x104, mem_rdata 0x89ABCDEF_00000000 -> mem_be 8'hF0, rsp_rdata 0x00000000_89ABCDEF.
REQ-040 Reset asserted while in WAIT, then mem_rvalid=1 -> no rsp_valid, state IDLE, req_ready 1 first cycle after reset release.
REQ-041 Back-to-back requests with req_valid held high -> second accepted the cycle after first rsp_valid, never earlier.
